assembler_line_sequencer: RTL and testbench
===========================================

# assembler_line_sequencer

Controller that drives the per-line instruction parser from a raw source-text character stream. It splits incoming text into lines and replays each line into the parser with the `new_line` / `new_character` strobes. It collects each finished 32-bit instruction and writes it to sequential instruction-memory addresses. It sits between the program text source (UART/ROM reader) and the instruction BRAM, and reports completion, instruction count and the first error with its line number.

## Interface
- `CHAR_PER_LINE`, 64: maximum characters per line, excluding the terminator.
- `IMEM_DEPTH`, 1024: number of instruction-memory words.
- `PARSE_TIMEOUT`, 16: cycles allowed between end-of-line and parser ready/error.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `start_in`  in  1  one-cycle pulse; begins assembly (honoured only in IDLE, DONE or ERROR).
- `char_valid_in`  in  1  source character valid.
- `char_in`  in  8  source ASCII character.
- `char_ready_out`  out  1  sequencer accepts `char_in` this cycle.
- `new_line_out`  out  1  parser restart strobe.
- `new_character_out`  out  1  parser character strobe.
- `character_out`  out  8  character to parser.
- `parse_ready_in`  in  1  parser instruction ready.
- `parse_error_in`  in  1  parser error.
- `instruction_in`  in  32  parser result.
- `imem_we_out`  out  1  instruction-memory write enable.
- `imem_addr_out`  out  $clog2(IMEM_DEPTH)  write address.
- `imem_data_out`  out  32  write data.
- `busy_out`, `done_out`  out  1 each  status.
- `error_out`  out  1  sticky error.
- `error_code_out`  out  2  error cause: 0 none, 1 parse, 2 line overflow, 3 imem full or timeout.
- `error_line_out`  out  16  1-based line number of the first error.
- `inst_count_out`  out  $clog2(IMEM_DEPTH)+1  instructions written.

## Operation
- States: IDLE, START_LINE, STREAM, WAIT_PARSE, WRITE, DONE, ERROR.
- IDLE → START_LINE on `start_in`.
  - Clears all counters, error fields and the address.
  - Sets the line number to 1.
- START_LINE:
  - Holds for exactly one cycle with `new_line_out`=1.
  - Clears the char count and the `seen_text` flag.
  - Goes to STREAM.
- STREAM:
  - `char_ready_out`=1.
  - On a handshake with an ordinary character: next cycle `new_character_out`=1 and `character_out`=char; the char count increments.
  - Any character other than space, tab or CR sets `seen_text`.
  - CR (0x0D) is consumed and dropped.
  - LF (0x0A):
    - With `seen_text`=1 → WAIT_PARSE.
    - With `seen_text`=0 (blank line) → line number +1, then START_LINE.
  - NUL (0x00) or EOT (0x04) is end of file:
    - A pending non-blank line goes through WAIT_PARSE/WRITE first.
    - Then DONE.
  - A character accepted while the char count equals `CHAR_PER_LINE` → ERROR, code 2.
- WAIT_PARSE:
  - `parse_error_in` → ERROR, code 1. Error wins if `parse_error_in` and `parse_ready_in` are simultaneous.
  - `parse_ready_in` → latch `instruction_in`, then WRITE.
- WRITE:
  - If `inst_count_out`==`IMEM_DEPTH` → ERROR, code 3, no write.
  - Otherwise, for one cycle: `imem_we_out`=1, `imem_data_out`=latched instruction, `imem_addr_out`=current address.
  - Then address +1, count +1, line +1.
  - Next state is START_LINE, or DONE if EOF is pending.
- DONE and ERROR:
  - Hold all results stable; `char_ready_out`=0.
  - `start_in` restarts as from IDLE.
- `error_line_out` records the line number current when ERROR is entered. It is written only on that entry.
- The line counter saturates at 0xFFFF.
- `busy_out` is 1 in START_LINE, STREAM, WAIT_PARSE and WRITE.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - `error_code_out`=0, `error_line_out`=0, `inst_count_out`=0, `imem_addr_out`=0.
- Async assertion of `rst_n_in` mid-operation aborts immediately: no further write or strobe. Release is synchronous to `clk_in`.
- Per-character latency: handshake at cycle N → `new_character_out` at N+1.
- At most one character is accepted per cycle.
- The LF handshake at N → WAIT_PARSE from N+1. The final character strobe (N) precedes WAIT_PARSE.
- `parse_ready_in` seen at cycle M → `imem_we_out` at M+1 → START_LINE at M+2 → next `char_ready_out` at M+3.
- `start_in` is ignored while `busy_out`=1.

## Configuration
- `SEQ_PARSE_TIMEOUT_EN` defined:
  - WAIT_PARSE counts cycles.
  - If `PARSE_TIMEOUT` cycles pass with neither ready nor error → ERROR, code 3.
- Not defined:
  - WAIT_PARSE waits indefinitely.
  - Code 3 arises only from imem full.

## Structure
- The shared `assembler_constants` package holds:
  - The state enum `seq_state_t`.
  - The error-code enum `seq_err_t`.
  - The ASCII constants `ASCII_LF`, `ASCII_CR`, `ASCII_SP`, `ASCII_TAB`, `ASCII_NUL`, `ASCII_EOT`.
- The block is a single module. The only natural sub-module is the parse watchdog, `seq_timeout_counter`, instantiated under the macro.

## Test plan
- Text "add x1,x2,x3\n" with parser stub asserting ready and 0x003100B3 → one write at addr 0 with data 0x003100B3; `inst_count_out`=1.
- "\n\r\n  \nnop\n" followed by NUL → exactly one write, at addr 0; `done_out`=1; 3 blank lines produce no `new_line` beyond their START_LINE pulses.
- Stub raises `parse_error_in` on line 3 of 4 → `error_out`=1, `error_code_out`=1, `error_line_out`=3, 2 writes made.
- 65-character line with `CHAR_PER_LINE`=64 → ERROR code 2 on the 65th handshake; that character is not forwarded.
- `IMEM_DEPTH`=4 with 5 lines → 4 writes, then ERROR code 3.
- With `SEQ_PARSE_TIMEOUT_EN` and a silent stub → ERROR code 3 exactly 16 cycles after WAIT_PARSE is entered.
- `rst_n_in` low mid-STREAM → all outputs 0 asynchronously.

Source files
------------

// File: rtl/assembler_line_sequencer_pkg.sv
// Shared constants for the assembler front end: sequencer state/error enums
// and the ASCII codes the line splitter reacts to.
package assembler_constants;

    typedef enum logic [2:0] {
        IDLE,
        START_LINE,
        STREAM,
        WAIT_PARSE,
        WRITE,
        DONE,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PARSE    = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_FULL     = 2'd3
    } seq_err_t;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_EOT = 8'h04;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    // Characters that do not make a line non-blank.
    function automatic logic is_space(input logic [7:0] ch);
        return (ch == ASCII_SP) || (ch == ASCII_TAB) || (ch == ASCII_CR);
    endfunction

endpackage

// File: rtl/assembler_line_sequencer_if.sv
// Character source, parser and instruction-memory signals of the line sequencer.
// master = sequencer side, slave = environment (source, parser, BRAM).
interface assembler_line_sequencer_if #(
    parameter int IMEM_DEPTH = 1024
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          char_valid_in;
    logic [7:0]    char_in;
    logic          char_ready_out;
    logic          new_line_out;
    logic          new_character_out;
    logic [7:0]    character_out;
    logic          parse_ready_in;
    logic          parse_error_in;
    logic [31:0]   instruction_in;
    logic          imem_we_out;
    logic [AW-1:0] imem_addr_out;
    logic [31:0]   imem_data_out;

    modport master (
        input  char_valid_in, char_in, parse_ready_in, parse_error_in, instruction_in,
        output char_ready_out, new_line_out, new_character_out, character_out,
               imem_we_out, imem_addr_out, imem_data_out
    );

    modport slave (
        output char_valid_in, char_in, parse_ready_in, parse_error_in, instruction_in,
        input  char_ready_out, new_line_out, new_character_out, character_out,
               imem_we_out, imem_addr_out, imem_data_out
    );

endinterface

// File: rtl/assembler_line_sequencer_timeout.sv
// Parse watchdog: counts cycles while run_in is high and flags the last one
// of a LIMIT-cycle window. Used only when SEQ_PARSE_TIMEOUT_EN is defined.
module seq_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic run_in,
    output logic expired_out
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)          cnt <= '0;
        else if (!run_in)       cnt <= '0;
        else if (cnt != LAST)   cnt <= cnt + W'(1);
    end

    assign expired_out = run_in && (cnt == LAST);

endmodule

// File: rtl/assembler_line_sequencer.sv
// Splits a source-text stream into lines, replays each into the parser and writes
// the resulting instructions to consecutive IMEM words. SEQ_PARSE_TIMEOUT_EN adds a parse watchdog.
module assembler_line_sequencer
    import assembler_constants::*;
#(
    parameter int CHAR_PER_LINE = 64,
    parameter int IMEM_DEPTH    = 1024,
    parameter int PARSE_TIMEOUT = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    assembler_line_sequencer_if.master    bus,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out,
    output logic [1:0]                    error_code_out,
    output logic [15:0]                   error_line_out,
    output logic [$clog2(IMEM_DEPTH):0]   inst_count_out
);
    localparam int AW    = $clog2(IMEM_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CC_W  = $clog2(CHAR_PER_LINE + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IMEM_DEPTH);
    localparam logic [CC_W-1:0]  CPL  = CC_W'(CHAR_PER_LINE);

    seq_state_t      state;
    logic [CC_W-1:0] cc_q;
    logic            seen_q;
    logic            eof_q;
    logic [15:0]     line_q;
    logic [15:0]     line_inc;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic [7:0]      char_q;
    logic            char_ready_q;
    logic            new_line_q;
    logic            new_char_q;
    logic            we_q;
    logic [7:0]      c;

    assign c        = bus.char_in;
    assign line_inc = (line_q == 16'hFFFF) ? line_q : line_q + 16'd1;

`ifdef SEQ_PARSE_TIMEOUT_EN
    logic timeout;
    seq_timeout_counter #(.LIMIT(PARSE_TIMEOUT)) u_watchdog (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .run_in      (state == WAIT_PARSE),
        .expired_out (timeout)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(PARSE_TIMEOUT);
`endif

    // Every state-dependent output is registered alongside the state itself.
    task automatic go(input seq_state_t s);
        state        <= s;
        char_ready_q <= (s == STREAM);
        new_line_q   <= (s == START_LINE);
        busy_out     <= s inside {START_LINE, STREAM, WAIT_PARSE, WRITE};
        done_out     <= (s == DONE);
        error_out    <= (s == ERROR);
    endtask

    task automatic fail(input seq_err_t e);
        error_code_out <= e;
        error_line_out <= line_q;
        go(ERROR);
    endtask

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            cc_q           <= '0;
            seen_q         <= 1'b0;
            eof_q          <= 1'b0;
            line_q         <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            char_q         <= '0;
            char_ready_q   <= 1'b0;
            new_line_q     <= 1'b0;
            new_char_q     <= 1'b0;
            we_q           <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
            error_code_out <= '0;
            error_line_out <= '0;
            inst_count_out <= '0;
        end else begin
            new_char_q <= 1'b0;
            we_q       <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_in) begin
                        inst_count_out <= '0;
                        addr_q         <= '0;
                        error_code_out <= ERR_NONE;
                        error_line_out <= '0;
                        line_q         <= 16'd1;
                        eof_q          <= 1'b0;
                        go(START_LINE);
                    end
                end
                START_LINE: begin
                    cc_q   <= '0;
                    seen_q <= 1'b0;
                    go(STREAM);
                end
                STREAM: begin
                    if (bus.char_valid_in && char_ready_q) begin
                        if (c == ASCII_LF) begin
                            if (seen_q) go(WAIT_PARSE);
                            else begin
                                line_q <= line_inc;
                                go(START_LINE);
                            end
                        end else if (c == ASCII_NUL || c == ASCII_EOT) begin
                            if (seen_q) begin
                                eof_q <= 1'b1;
                                go(WAIT_PARSE);
                            end else go(DONE);
                        end else if (c == ASCII_CR) begin
                            // dropped: CRLF sources behave like LF sources
                        end else if (cc_q == CPL) begin
                            fail(ERR_OVERFLOW);
                        end else begin
                            new_char_q <= 1'b1;
                            char_q     <= c;
                            cc_q       <= cc_q + CC_W'(1);
                            if (!is_space(c)) seen_q <= 1'b1;
                        end
                    end
                end
                WAIT_PARSE: begin
                    if (bus.parse_error_in) fail(ERR_PARSE);
                    else if (bus.parse_ready_in) begin
                        // Write strobe is decided here so it lines up with the WRITE cycle.
                        data_q <= bus.instruction_in;
                        we_q   <= (inst_count_out != FULL);
                        go(WRITE);
                    end
`ifdef SEQ_PARSE_TIMEOUT_EN
                    else if (timeout) fail(ERR_FULL);
`endif
                end
                WRITE: begin
                    if (inst_count_out == FULL) fail(ERR_FULL);
                    else begin
                        addr_q         <= addr_q + AW'(1);
                        inst_count_out <= inst_count_out + CNT_W'(1);
                        line_q         <= line_inc;
                        go(eof_q ? DONE : START_LINE);
                    end
                end
                default: go(IDLE);
            endcase
        end
    end

    assign bus.char_ready_out    = char_ready_q;
    assign bus.new_line_out      = new_line_q;
    assign bus.new_character_out = new_char_q;
    assign bus.character_out     = char_q;
    assign bus.imem_we_out       = we_q;
    assign bus.imem_addr_out     = addr_q;
    assign bus.imem_data_out     = data_q;

endmodule

// File: tb/tb_assembler_line_sequencer.sv
// Randomized and directed bench for assembler_line_sequencer with an event-level
// model of line splitting, parsing and IMEM writes.
module tb_assembler_line_sequencer;
    import assembler_constants::*;

    localparam int DEPTH = 4;
    localparam int CPL   = 64;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic start_in = 1'b0;
    logic busy_out, done_out, error_out;
    logic [1:0] error_code_out;
    logic [15:0] error_line_out;
    logic [$clog2(DEPTH):0] inst_count_out;

    assembler_line_sequencer_if #(.IMEM_DEPTH(DEPTH)) bus();

    assembler_line_sequencer #(.CHAR_PER_LINE(CPL), .IMEM_DEPTH(DEPTH), .PARSE_TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .bus(bus),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .error_code_out(error_code_out), .error_line_out(error_line_out),
        .inst_count_out(inst_count_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0;
    logic [7:0] prog[$];
    logic [7:0] exp_chars[$];
    int exp_addr[$];
    logic [31:0] exp_data[$];
    int nl_seen, chr_seen, we_seen, last_addr;
    logic [31:0] last_data;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard: every strobe the DUT emits must match the model's next expectation.
    initial forever begin
        @(negedge clk_in);
        if (rst_n_in) begin
            if (bus.new_line_out) nl_seen++;
            if (bus.new_character_out) begin
                chr_seen++;
                if (exp_chars.size() == 0) note_fail("unexpected character strobe");
                else chk("char", bus.character_out, exp_chars.pop_front());
            end
            if (bus.imem_we_out) begin
                we_seen++;
                last_addr = int'(bus.imem_addr_out);
                last_data = bus.imem_data_out;
                if (exp_addr.size() == 0) note_fail("unexpected imem write");
                else begin
                    chk("wr_addr", bus.imem_addr_out, exp_addr.pop_front());
                    chk("wr_data", bus.imem_data_out, exp_data.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] ch, output bit ok);
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        repeat (gap) @(negedge clk_in);
        bus.char_valid_in = 1'b1;
        bus.char_in = ch;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.char_ready_out) begin ok = 1'b1; break; end
            @(negedge clk_in);
        end
        if (ok) @(negedge clk_in);
        bus.char_valid_in = 1'b0;
        if (!ok) note_fail("char handshake timeout");
    endtask

    task automatic respond(input bit err, input bit both, input logic [31:0] d);
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
        bus.parse_error_in = err;
        bus.parse_ready_in = !err || both;
        bus.instruction_in = d;
        @(negedge clk_in);
        bus.parse_error_in = 1'b0;
        bus.parse_ready_in = 1'b0;
    endtask

    task automatic add(input string s);
        for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
    endtask

    // Model: walk the text line by line and predict strobes, writes and final status.
    task automatic run_prog(input int err_line, input bit both, input logic [31:0] fixed, input bit timing);
        int cc, line, writes, nl_exp, e_code, e_line;
        bit seen, stop, ok, e_done, term, ord;
        logic [7:0] ch;
        logic [31:0] d;
        cc = 0; line = 1; writes = 0; nl_exp = 1; e_code = 0; e_line = 0;
        seen = 0; stop = 0; e_done = 0;
        exp_chars.delete(); exp_addr.delete(); exp_data.delete();
        nl_seen = 0; chr_seen = 0; we_seen = 0;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        for (int i = 0; i < prog.size() && !stop; i++) begin
            ch = prog[i];
            term = (ch == ASCII_LF) || (ch == ASCII_NUL) || (ch == ASCII_EOT);
            ord = !term && (ch != ASCII_CR);
            if (ord && cc == CPL) begin
                send(ch, ok);
                e_code = 2; e_line = line; stop = 1;
            end else begin
                if (ord) exp_chars.push_back(ch);
                send(ch, ok);
                if (!ok) stop = 1;
                else if (ord) begin
                    cc++;
                    if (ch != ASCII_SP && ch != ASCII_TAB) seen = 1;
                end else if (term && !seen) begin
                    if (ch == ASCII_LF) begin line++; nl_exp++; cc = 0; end
                    else begin e_done = 1; stop = 1; end
                end else if (term) begin
                    if (timing) chk("lf_to_wait_ready_low", bus.char_ready_out, 0);
                    d = (fixed != 0) ? fixed : $urandom;
                    if (line == err_line) begin
                        respond(1'b1, both, d);
                        e_code = 1; e_line = line; stop = 1;
                    end else begin
                        if (writes < DEPTH) begin exp_addr.push_back(writes); exp_data.push_back(d); end
                        respond(1'b0, 1'b0, d);
                        if (writes == DEPTH) begin
                            e_code = 3; e_line = line; stop = 1;
                        end else begin
                            writes++; line++; cc = 0; seen = 0;
                            if (timing) chk("we_at_m1", bus.imem_we_out, 1);
                            if (ch == ASCII_LF) begin
                                nl_exp++;
                                if (timing) begin
                                    @(negedge clk_in);
                                    chk("newline_at_m2", bus.new_line_out, 1);
                                    chk("ready_low_m2", bus.char_ready_out, 0);
                                    @(negedge clk_in);
                                    chk("ready_at_m3", bus.char_ready_out, 1);
                                end
                            end else begin
                                e_done = 1; stop = 1;
                            end
                        end
                    end
                end
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done_out || error_out) begin ok = 1'b1; break; end
            @(negedge clk_in);
        end
        if (!ok) note_fail("program end timeout");
        chk("done", done_out, e_done);
        chk("error", error_out, e_code != 0);
        chk("err_code", error_code_out, e_code);
        chk("err_line", error_line_out, e_line);
        chk("inst_count", inst_count_out, writes);
        chk("new_lines", nl_seen, nl_exp);
        chk("chars_pending", exp_chars.size(), 0);
        chk("writes_pending", exp_addr.size(), 0);
        chk("busy_end", busy_out, 0);
    endtask

    task automatic gen();
        int n, len, r;
        bit eof_line;
        prog = {};
        n = $urandom_range(1, 6);
        eof_line = 0;
        for (int l = 0; l < n; l++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 2)) begin
                    r = $urandom_range(0, 2);
                    prog.push_back(r == 0 ? ASCII_SP : (r == 1 ? ASCII_TAB : ASCII_CR));
                end
            end else begin
                len = $urandom_range(1, 12);
                for (int k = 0; k < len; k++) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) prog.push_back(ASCII_SP);
                    else if (r == 1) prog.push_back(ASCII_TAB);
                    else if (r == 2) prog.push_back(ASCII_CR);
                    else prog.push_back(8'(8'h61 + $urandom_range(0, 25)));
                end
            end
            if (l == n - 1 && $urandom_range(0, 1) == 1) begin
                prog.push_back($urandom_range(0, 1) ? ASCII_EOT : ASCII_NUL);
                eof_line = 1;
            end else prog.push_back(ASCII_LF);
        end
        if (!eof_line) prog.push_back($urandom_range(0, 1) ? ASCII_EOT : ASCII_NUL);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.char_valid_in = 1'b0; bus.char_in = '0;
        bus.parse_ready_in = 1'b0; bus.parse_error_in = 1'b0; bus.instruction_in = '0;
        #3;
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_error", error_out, 0);
        chk("rst_code", error_code_out, 0);
        chk("rst_line", error_line_out, 0);
        chk("rst_count", inst_count_out, 0);
        chk("rst_addr", bus.imem_addr_out, 0);
        chk("rst_ready", bus.char_ready_out, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Single instruction line
        prog = {}; add("add x1,x2,x3\n"); prog.push_back(ASCII_NUL);
        run_prog(0, 0, 32'h003100B3, 1);
        chk("t1_count", inst_count_out, 1);
        chk("t1_data", last_data, 32'h003100B3);
        chk("t1_addr", last_addr, 0);
        chk("t1_done", done_out, 1);

        // Blank lines, CR and whitespace-only line before one instruction
        prog = {}; add("\n"); prog.push_back(ASCII_CR); add("\n  \nnop\n"); prog.push_back(ASCII_NUL);
        run_prog(0, 0, 0, 0);
        chk("t2_newlines", nl_seen, 5);
        chk("t2_writes", we_seen, 1);
        chk("t2_addr", last_addr, 0);
        chk("t2_done", done_out, 1);

        // Parse error on line 3 of 4, with ready raised at the same time
        prog = {}; add("nop\nnop\nadd\nsub\n"); prog.push_back(ASCII_NUL);
        run_prog(3, 1, 0, 0);
        chk("t3_code", error_code_out, 1);
        chk("t3_line", error_line_out, 3);
        chk("t3_count", inst_count_out, 2);

        // 65-character line
        prog = {}; repeat (65) prog.push_back(8'h61); add("\n"); prog.push_back(ASCII_NUL);
        run_prog(0, 0, 0, 0);
        chk("t4_code", error_code_out, 2);
        chk("t4_line", error_line_out, 1);
        chk("t4_chars", chr_seen, 64);

        // Five instructions into a four-word memory
        prog = {}; repeat (5) add("nop\n"); prog.push_back(ASCII_NUL);
        run_prog(0, 0, 0, 0);
        chk("t5_count", inst_count_out, 4);
        chk("t5_writes", we_seen, 4);
        chk("t5_code", error_code_out, 3);
        chk("t5_line", error_line_out, 5);

`ifdef SEQ_PARSE_TIMEOUT_EN
        // Silent parser: watchdog fires 16 cycles into WAIT_PARSE
        exp_chars.delete();
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        exp_chars.push_back(8'h6E); send(8'h6E, ok);
        exp_chars.push_back(8'h6F); send(8'h6F, ok);
        send(ASCII_LF, ok);
        repeat (15) @(negedge clk_in);
        chk("to_not_yet", error_out, 0);
        @(negedge clk_in);
        chk("to_error", error_out, 1);
        chk("to_code", error_code_out, 3);
        chk("to_line", error_line_out, 1);
`endif

        for (int p = 0; p < 30; p++) begin
            gen();
            run_prog(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, 1'($urandom_range(0, 1)), 0, 0);
        end

        // Asynchronous reset in the middle of a line
        exp_chars.delete(); exp_addr.delete(); exp_data.delete();
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        exp_chars.push_back(8'h61); send(8'h61, ok);
        exp_chars.push_back(8'h62); send(8'h62, ok);
        chk("pre_rst_strobe", bus.new_character_out, 1);
        #1 rst_n_in = 1'b0;
        #1;
        chk("arst_strobe", bus.new_character_out, 0);
        chk("arst_ready", bus.char_ready_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_we", bus.imem_we_out, 0);
        chk("arst_char", bus.character_out, 0);
        @(negedge clk_in); rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_busy", busy_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
